pool2x2_stream: RTL and testbench
=================================

POOL2X2_STREAM -- requirements
Module: pool2x2_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed input sample width (ReLU output).
REQ-002 SHALL have parameter OUT_WIDTH, default 8, signed output sample width (memory write width).
REQ-003 SHALL have parameter IN_WIDTH, default 26, conv feature-map columns per row.
REQ-004 SHALL have parameter IN_HEIGHT, default 26, conv feature-map rows per frame.
REQ-005 SHALL use one clock and a synchronous active-high reset.
REQ-006 Port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-007 Port rst_i, input, 1, synchronous active-high reset.
REQ-008 Port clear_i, input, 1, synchronous frame restart pulse.
REQ-009 Port in_data_i, input, DATA_WIDTH, signed feature-map sample, raster order.
REQ-010 Port in_valid_i, input, 1, sample valid.
REQ-011 Port in_ready_o, output, 1, sample accepted when in_valid_i && in_ready_o.
REQ-012 Port out_data_o, output, OUT_WIDTH, pooled sample.
REQ-013 Port out_valid_o, output, 1, pooled sample valid.
REQ-014 Port out_ready_i, input, 1, downstream accepts when out_valid_o && out_ready_i.
REQ-015 Port frame_done_o, output, 1, one-cycle pulse after the last pooled sample of a frame is accepted downstream.

Function
REQ-016 SHALL perform 2x2 stride-2 max pooling; output map is floor(IN_WIDTH/2) x floor(IN_HEIGHT/2) (13x13 default).
REQ-017 SHALL track col (0..IN_WIDTH-1) and row (0..IN_HEIGHT-1) counters, advancing only on accepted input; col wraps to 0 and row increments at col==IN_WIDTH-1; both wrap to 0 after the last pixel of the frame.
REQ-018 Even row, even col: SHALL latch sample in horizontal register h.
REQ-019 Even row, odd col: SHALL write max(h, sample) to row buffer entry col/2.
REQ-020 Odd row, even col: SHALL latch sample in h.
REQ-021 Odd row, odd col: SHALL compute max(rowbuf[col/2], h, sample) and register it on out_data_o with out_valid_o=1 the next cycle (latency 1 cycle from completing input).
REQ-022 With odd IN_WIDTH/IN_HEIGHT, SHALL accept and discard the trailing column/row without producing output.
REQ-023 Comparisons SHALL be signed over DATA_WIDTH.
REQ-024 in_ready_o SHALL equal (!out_valid_o || out_ready_i) && !clear_i.
REQ-025 out_valid_o SHALL hold with stable out_data_o until accepted; cleared on acceptance unless a new result is produced the same cycle.
REQ-026 frame_done_o SHALL pulse one cycle after the acceptance of the output from row IN_HEIGHT-1 (or last pooled row), col last odd column.
REQ-027 clear_i SHALL zero col, row, h and drop any pending out_valid_o in the same cycle; no input is accepted that cycle; clear_i overrides a simultaneous output handshake and frame_done_o.

Reset
REQ-028 On rst_i: out_valid_o=0, out_data_o=0, frame_done_o=0, col=0, row=0, h=0; in_ready_o=1 the cycle after reset deasserts.
REQ-029 Row buffer contents SHALL NOT require reset (always written before read in a frame).
REQ-030 Reset mid-frame SHALL discard partial frame; next accepted sample is row 0 col 0.

Configuration
REQ-031 Macro POOL2X2_SAT_EN defined: out_data_o SHALL be the pooled value saturated to signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-032 Macro POOL2X2_SAT_EN undefined: out_data_o SHALL be the low OUT_WIDTH bits of the pooled value (truncation).

Structure
REQ-033 Package cnn_pkg SHALL hold CNN_IMG_WIDTH=28, CONV_OUT_WIDTH=26, POOL_OUT_WIDTH=13 and the signed sample typedef shared with the conv/ReLU stages.
REQ-034 Row buffer SHALL be sub-module pool_row_buffer: floor(IN_WIDTH/2) entries x DATA_WIDTH, one write and one read port, combinational read.

Verification
REQ-035 4x4 frame (IN_WIDTH=IN_HEIGHT=4), samples 1..16 raster, out_ready_i=1 -> outputs 6, 8, 14, 16, frame_done_o pulse after 16.
REQ-036 Negative values block {-5,-3,-9,-7} -> output -3 (signed compare).
REQ-037 Value 300 with SAT_EN -> 127; without -> 44 (300 mod 256).
REQ-038 out_ready_i held 0 after first result -> in_ready_o=0, out_data_o stable, no sample lost; release -> sequence identical to REQ-035.
REQ-039 clear_i asserted after sample 7 then frame replayed from 1 -> outputs identical to REQ-035, no stale output.
REQ-040 5x5 frame samples 1..25 -> outputs 7, 9, 17, 19; column 4 and row 4 discarded.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN dimensions and sample type for the conv -> ReLU -> pool pipeline.
package cnn_pkg;

    localparam int unsigned CNN_IMG_WIDTH  = 28;
    localparam int unsigned CONV_OUT_WIDTH = 26;
    localparam int unsigned POOL_OUT_WIDTH = 13;
    localparam int unsigned SAMPLE_WIDTH   = 32;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    // Index width that stays legal (>= 1) for degenerate single-entry ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Pooling row buffer: one pair-max per horizontal pool window of the even row.
module pool_row_buffer #(
    parameter int unsigned DEPTH      = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    // No reset: every entry is written on the even row before the odd row reads it.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 signed max pooling over a raster feature map.
// Define POOL2X2_SAT_EN to saturate the pooled value to OUT_WIDTH instead of truncating.
module pool2x2_stream
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned IN_WIDTH   = CONV_OUT_WIDTH,
    parameter int unsigned IN_HEIGHT  = CONV_OUT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [OUT_WIDTH-1:0]  out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  frame_done_o
);

    localparam int unsigned POOL_W = IN_WIDTH / 2;
    localparam int unsigned POOL_H = IN_HEIGHT / 2;
    localparam int unsigned COL_W  = clog2_min1(IN_WIDTH);
    localparam int unsigned ROW_W  = clog2_min1(IN_HEIGHT);
    localparam int unsigned ADDR_W = clog2_min1(POOL_W);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IN_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_POOL_LAST = COL_W'(2 * POOL_W - 1);
    localparam logic [ROW_W-1:0] ROW_POOL_LAST = ROW_W'(2 * POOL_H - 1);

    logic [COL_W-1:0]             col_q;
    logic [ROW_W-1:0]             row_q;
    logic signed [DATA_WIDTH-1:0] h_q;
    logic                         out_last_q;

    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [DATA_WIDTH-1:0] rb_rd_data;
    logic signed [DATA_WIDTH-1:0] max_h;
    logic signed [DATA_WIDTH-1:0] max_v;
    logic [OUT_WIDTH-1:0]         out_next;
    logic [ADDR_W-1:0]            rb_addr;
    logic                         accept;
    logic                         in_window;
    logic                         rb_wr_en;
    logic                         produce;

    assign in_ready_o = (!out_valid_o || out_ready_i) && !clear_i;
    assign accept     = in_valid_i && in_ready_o;
    assign sample     = $signed(in_data_i);

    // Trailing column/row of an odd-sized map never enters a pool window.
    assign in_window  = (col_q <= COL_POOL_LAST) && (row_q <= ROW_POOL_LAST);
    assign rb_wr_en   = accept && in_window && col_q[0] && !row_q[0];
    assign produce    = accept && in_window && col_q[0] && row_q[0];
    assign rb_addr    = ADDR_W'(col_q >> 1);

    assign max_h = (sample > h_q) ? sample : h_q;
    assign max_v = (rb_rd_data > max_h) ? rb_rd_data : max_h;

    pool_row_buffer #(
        .DEPTH      (POOL_W),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_row_buffer (
        .clk_i     (clk_i),
        .wr_en_i   (rb_wr_en),
        .wr_addr_i (rb_addr),
        .wr_data_i (max_h),
        .rd_addr_i (rb_addr),
        .rd_data_o (rb_rd_data)
    );

`ifdef POOL2X2_SAT_EN
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
        {{(DATA_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    // Clamp into the signed OUT_WIDTH range.
    always_comb begin
        out_next = max_v[OUT_WIDTH-1:0];
        if (max_v > SAT_MAX) begin
            out_next = SAT_MAX[OUT_WIDTH-1:0];
        end else if (max_v < SAT_MIN) begin
            out_next = SAT_MIN[OUT_WIDTH-1:0];
        end
    end
`else
    logic unused_max_hi;

    assign out_next      = max_v[OUT_WIDTH-1:0];
    assign unused_max_hi = ^max_v[DATA_WIDTH-1:OUT_WIDTH];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            out_data_o   <= '0;
            out_valid_o  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_o <= 1'b0;
        end else if (clear_i) begin
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            out_valid_o  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= out_valid_o && out_ready_i && out_last_q;
            if (accept) begin
                if (!col_q[0]) begin
                    h_q <= sample;
                end
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
            // Accept implies the output slot is free, so a new result never overwrites one.
            if (produce) begin
                out_valid_o <= 1'b1;
                out_data_o  <= out_next;
                out_last_q  <= (row_q == ROW_POOL_LAST) && (col_q == COL_POOL_LAST);
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Scoreboard bench for pool2x2_stream: a 4x4 and a 5x5 instance against a frame-level max model.
module tb_pool2x2_stream;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        clear     [2];
    logic [31:0] in_data   [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  out_data  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        frame_done[2];

    exp_t q0[$];
    exp_t q1[$];
    int   fbuf[64];
    int   bp_mode;
    logic chk_rst;
    logic end_req;

    int   total;
    int   bad;
    logic pend     [2];
    logic hold     [2];
    logic [7:0] hold_data [2];

    pool2x2_stream #(
        .DATA_WIDTH (32), .OUT_WIDTH (8), .IN_WIDTH (4), .IN_HEIGHT (4)
    ) u_dut4 (
        .clk_i (clk), .rst_i (rst), .clear_i (clear[0]),
        .in_data_i (in_data[0]), .in_valid_i (in_valid[0]), .in_ready_o (in_ready[0]),
        .out_data_o (out_data[0]), .out_valid_o (out_valid[0]), .out_ready_i (out_ready[0]),
        .frame_done_o (frame_done[0])
    );

    pool2x2_stream #(
        .DATA_WIDTH (32), .OUT_WIDTH (8), .IN_WIDTH (5), .IN_HEIGHT (5)
    ) u_dut5 (
        .clk_i (clk), .rst_i (rst), .clear_i (clear[1]),
        .in_data_i (in_data[1]), .in_valid_i (in_valid[1]), .in_ready_o (in_ready[1]),
        .out_data_o (out_data[1]), .out_valid_o (out_valid[1]), .out_ready_i (out_ready[1]),
        .frame_done_o (frame_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            case (bp_mode)
                0:       out_ready[k] = 1'b1;
                1:       out_ready[k] = ($urandom_range(0, 2) != 0);
                default: out_ready[k] = 1'b0;
            endcase
        end
    end

    function automatic logic [7:0] conv(input int m);
`ifdef POOL2X2_SAT_EN
        if (m > 127)  return 8'h7F;
        if (m < -128) return 8'h80;
        return 8'(m);
`else
        return 8'(m);
`endif
    endfunction

    function automatic bit q_pop(input int k, output exp_t e);
        e = '0;
        if (k == 0) begin
            if (q0.size() == 0) return 1'b0;
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            e = q1.pop_front();
        end
        return 1'b1;
    endfunction

    // Expected outputs: one per 2x2 block fully covered by the first n raster samples.
    task automatic model_push(input int k, input int w, input int h, input int n);
        int   b0;
        int   m;
        exp_t e;
        for (int by = 0; by < h / 2; by++) begin
            for (int bx = 0; bx < w / 2; bx++) begin
                b0 = 2 * by * w + 2 * bx;
                if (b0 + w + 1 < n) begin
                    m = fbuf[b0];
                    if (fbuf[b0 + 1] > m)     m = fbuf[b0 + 1];
                    if (fbuf[b0 + w] > m)     m = fbuf[b0 + w];
                    if (fbuf[b0 + w + 1] > m) m = fbuf[b0 + w + 1];
                    e.data = conv(m);
                    e.last = (by == h / 2 - 1) && (bx == w / 2 - 1);
                    if (k == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
        end
    endtask

    task automatic send(input int k, input int d);
        int t;
        t = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        forever begin
            @(negedge clk);
            if (in_ready[k]) break;
            t++;
            if (t > 500) begin
                $display("FAIL drv_timeout dut%0d: in_ready stuck 0 for %0d cycles, required 1", k, t);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input int k, input int w, input int h, input int n);
        model_push(k, w, h, n);
        for (int i = 0; i < n; i++) send(k, fbuf[i]);
    endtask

    task automatic fill_seq(input int n);
        for (int i = 0; i < n; i++) fbuf[i] = i + 1;
    endtask

    task automatic fill_rand(input int n, input int wide);
        for (int i = 0; i < n; i++) begin
            if (wide != 0 && $urandom_range(0, 1) == 1) fbuf[i] = $signed($urandom);
            else fbuf[i] = int'($urandom_range(0, 600)) - 300;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        chk_rst = 1'b1;
        @(posedge clk);
        #1;
        chk_rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks flow-control rules.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pend[k] = 1'b0;
                hold[k] = 1'b0;
            end else begin
                if (chk_rst) begin
                    total++;
                    if (out_valid[k] !== 1'b0 || frame_done[k] !== 1'b0 ||
                        out_data[k] !== 8'h00 || in_ready[k] !== 1'b1) begin
                        bad++;
                        $display("FAIL reset_state dut%0d: valid=%b done=%b data=%h ready=%b, required 0 0 00 1",
                                 k, out_valid[k], frame_done[k], out_data[k], in_ready[k]);
                    end
                end
                total++;
                if (in_ready[k] !== ((!out_valid[k] || out_ready[k]) && !clear[k])) begin
                    bad++;
                    $display("FAIL in_ready dut%0d: got %b, required %b", k, in_ready[k],
                             (!out_valid[k] || out_ready[k]) && !clear[k]);
                end
                if (pend[k] || frame_done[k]) begin
                    total++;
                    if (frame_done[k] !== pend[k]) begin
                        bad++;
                        $display("FAIL frame_done dut%0d: got %b, required %b", k, frame_done[k], pend[k]);
                    end
                end
                if (hold[k]) begin
                    total++;
                    if (out_valid[k] !== 1'b1 || out_data[k] !== hold_data[k]) begin
                        bad++;
                        $display("FAIL hold_stable dut%0d: valid=%b data=%h, required 1 %h",
                                 k, out_valid[k], out_data[k], hold_data[k]);
                    end
                end
                pend[k] = 1'b0;
                hold[k] = 1'b0;
                if (out_valid[k] && out_ready[k] && !clear[k]) begin
                    total++;
                    if (!q_pop(k, e)) begin
                        bad++;
                        $display("FAIL unexpected_out dut%0d: got %h, required no output", k, out_data[k]);
                    end else begin
                        pend[k] = e.last;
                        if (out_data[k] !== e.data) begin
                            bad++;
                            $display("FAIL out_data dut%0d: got %h, required %h", k, out_data[k], e.data);
                        end
                    end
                end else if (out_valid[k] && !clear[k]) begin
                    hold[k]      = 1'b1;
                    hold_data[k] = out_data[k];
                end
            end
        end
        if (end_req) begin
            total++;
            if (q0.size() != 0) begin
                bad++;
                $display("FAIL missing_out dut0: got %0d outputs left, required 0", q0.size());
            end
            total++;
            if (q1.size() != 0) begin
                bad++;
                $display("FAIL missing_out dut1: got %0d outputs left, required 0", q1.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        bp_mode = 0;
        chk_rst = 1'b0;
        end_req = 1'b0;
        rst     = 1'b1;
        for (int k = 0; k < 2; k++) begin
            clear[k]     = 1'b0;
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
            pend[k]      = 1'b0;
            hold[k]      = 1'b0;
            hold_data[k] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Sequential 4x4 frame: 6, 8, 14, 16.
        fill_seq(16);
        run_frame(0, 4, 4, 16);

        // Signed compare on an all-negative block.
        fill_rand(16, 0);
        fbuf[0] = -5; fbuf[1] = -3; fbuf[4] = -9; fbuf[5] = -7;
        run_frame(0, 4, 4, 16);

        // Out-of-range values on both sides of the output range.
        for (int i = 0; i < 16; i++) fbuf[i] = int'($urandom_range(0, 40)) - 20;
        fbuf[0]  = 300;
        fbuf[3]  = 128;
        fbuf[8]  = -129; fbuf[9]  = -200; fbuf[12] = -300; fbuf[13] = -1000;
        fbuf[10] = -300; fbuf[11] = -300; fbuf[14] = -300; fbuf[15] = -300;
        run_frame(0, 4, 4, 16);

        // Downstream stalled for a while, then released.
        fill_seq(16);
        bp_mode = 2;
        fork
            run_frame(0, 4, 4, 16);
            begin
                repeat (30) @(posedge clk);
                bp_mode = 0;
            end
        join

        // Clear after sample 7 (with a sample offered during clear), then replay.
        repeat (3) @(posedge clk);
        #1;
        fill_seq(16);
        run_frame(0, 4, 4, 7);
        clear[0]    = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = 32'd99;
        @(posedge clk);
        #1;
        clear[0]    = 1'b0;
        in_valid[0] = 1'b0;
        run_frame(0, 4, 4, 16);

        // Reset mid-frame discards the partial frame.
        fill_seq(16);
        run_frame(0, 4, 4, 5);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        run_frame(0, 4, 4, 16);

        // Random frames under random backpressure.
        bp_mode = 1;
        for (int f = 0; f < 6; f++) begin
            fill_rand(16, 1);
            run_frame(0, 4, 4, 16);
        end

        // 5x5 frame: 7, 9, 17, 19, trailing column/row dropped.
        bp_mode = 0;
        fill_seq(25);
        run_frame(1, 5, 5, 25);
        bp_mode = 1;
        for (int f = 0; f < 3; f++) begin
            fill_rand(25, 1);
            run_frame(1, 5, 5, 25);
        end

        bp_mode = 0;
        for (int t = 0; t < 3000 && (q0.size() + q1.size()) != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        end_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL end_timeout: monitor did not finish, required finish");
        $fatal(1);
    end

endmodule
